dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage and a slow, block-wide data memory. It holds 16 lines of 32 bytes and serves MEM-stage loads and stores on a hit with no stall. On a miss it runs a write-back/refill sequence and holds the pipeline stalled until the line is resident. The stall output feeds the CPU's stall logic.

## Interface
Parameters:
- none: geometry is fixed at 16 lines × 256 bits, 23-bit tag.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite)
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  freeze pipeline
- mem_req_o  out  1  memory transaction request
- mem_write_o  out  1  1 = block write-back, 0 = block read
- mem_addr_o  out  32  block address, bits [4:0] = 0
- mem_data_o  out  256  write-back block
- mem_data_i  in  256  refill block
- mem_ack_i  in  1  one-cycle pulse: transaction complete
- miss_cnt_o  out  16  miss counter, saturates at 0xFFFF

## Operation
- Address split:
  - offset = addr[4:0]
  - word select = addr[4:2]
  - index = addr[8:5]
  - tag = addr[31:9]
- Per line storage: valid, dirty, 23-bit tag, 256-bit data.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Load hit: cpu_data_o = selected word, combinational, same cycle.
  - Store hit: the word is written and dirty is set at the next edge.
  - Miss: go to WRITEBACK if the victim is valid & dirty, else ALLOCATE. miss_cnt_o increments at that edge.
- WRITEBACK:
  - Drives mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - Drives mem_req_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
  - On mem_ack_i, the line takes mem_data_i, tag is updated, valid=1, dirty=0, and the state returns to IDLE.
  - The retried access then hits. A store merges into the refilled line and sets dirty.
- cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit). The CPU must hold addr, data and req stable while stalled.
- Memory contract:
  - Request signals stay stable until ack.
  - A WRITEBACK-to-ALLOCATE change with mem_req_o held high is a new transaction.
  - mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- cpu_data_o = 0 unless there is a load hit in IDLE.

## Timing
- Reset (rst_i=0 at a posedge) forces:
  - state IDLE, all valid/dirty = 0, miss_cnt_o = 0
  - mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0
  - tags and data do not care
- Reset mid-operation: an in-flight transaction is abandoned and mem_req_o drops after that edge. Dirty data is lost.
- Hit: 0 stall cycles.
- Clean miss: stall from the request cycle through the ack cycle, plus the retry cycle with stall low. Total stalled cycles = 1 + L, where L is the number of ALLOCATE cycles up to and including ack.
- Dirty miss: 1 + Lwb + Lrd stalled cycles.
- Ack in the first cycle of a state is legal (L=1).
- miss_cnt_o counts each miss exactly once, at the IDLE→miss edge, never on retry.

## Test plan
- **Cold load miss.** Reset, memory block 0 word0=5, ack 10 cycles after request; load 0x0.
  - Required: stall high 11 cycles, one read at mem_addr_o=0x0, then cpu_data_o=5 with stall low.
  - Required: miss_cnt_o=1.
- **Load hit.** Then load 0x4 (memory word1=7).
  - Required: cpu_data_o=7 the same cycle, stall 0, mem_req_o stays 0.
- **Store hit.** Store 0xDEADBEEF to 0x8, then load 0x8.
  - Required: returns 0xDEADBEEF, no memory traffic, line 0 dirty.
- **Dirty conflict miss.** Load 0x200 (index 0, tag 1).
  - Required: write-back at 0x0 with mem_data_o[95:64]=0xDEADBEEF, then a read at 0x200.
  - Required: miss_cnt_o=2, and a later load 0x8 misses again.
- **Clean store miss.** Store 0x1234 to 0x44.
  - Required: no write-back, read at 0x40, then word1 of line 2 = 0x1234 and dirty=1.
- **Reset during ALLOCATE.** Assert rst_i=0 for one edge in cycle 5 of ALLOCATE.
  - Required: mem_req_o=0 after that edge, miss_cnt_o=0, and a load 0x0 misses.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 16 lines x 32 bytes.
// Hits are served without stall; misses run an optional write-back followed by a refill.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [15:0]  miss_cnt_o
);

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e       r_state, w_state_next;
  logic [15:0]  r_valid, r_dirty;
  logic [22:0]  r_tag [16];
  logic [255:0] r_data [16];
  logic [15:0]  r_miss_cnt;

  logic [3:0]   w_index;
  logic [2:0]   w_word;
  logic [22:0]  w_tag;
  logic         w_hit, w_miss, w_store_hit, w_load_hit, w_fill;
  logic         w_unused_addr;

  assign w_index       = cpu_addr_i[8:5];
  assign w_word        = cpu_addr_i[4:2];
  assign w_tag         = cpu_addr_i[31:9];
  assign w_unused_addr = ^cpu_addr_i[1:0];

  assign w_hit       = cpu_req_i & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_miss      = (r_state == StIdle) & cpu_req_i & ~w_hit;
  assign w_store_hit = (r_state == StIdle) & w_hit & cpu_write_i;
  assign w_load_hit  = (r_state == StIdle) & w_hit & ~cpu_write_i;
  assign w_fill      = (r_state == StAllocate) & mem_ack_i;

  assign cpu_data_o  = w_load_hit ? r_data[w_index][{w_word, 5'b0} +: 32] : 32'h0;
  assign cpu_stall_o = (r_state != StIdle) | (cpu_req_i & ~w_hit);
  assign miss_cnt_o  = r_miss_cnt;

  // Memory request fields are decoded from state so reset clears them with no extra flops.
  always_comb begin
    w_state_next = r_state;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 256'h0;
    case (r_state)
      StIdle: begin
        if (w_miss) begin
          w_state_next = (r_valid[w_index] & r_dirty[w_index]) ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {r_tag[w_index], w_index, 5'b0};
        mem_data_o  = r_data[w_index];
        if (mem_ack_i) w_state_next = StAllocate;
      end
      StAllocate: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {w_tag, w_index, 5'b0};
        if (mem_ack_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_store_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_fill) begin
      r_data[w_index] <= mem_data_i;
      r_tag[w_index]  <= w_tag;
    end else if (rst_i && w_store_hit) begin
      r_data[w_index][{w_word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a memory responder checks each bus transaction
// against a queue of expected transactions pushed alongside the CPU stimulus.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;
  logic [15:0]  miss_cnt_o;

  always #5 clk_i = ~clk_i;

  dcache_controller u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_write_i (cpu_write_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i),
    .miss_cnt_o  (miss_cnt_o)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t         exp_q[$];
  logic [255:0] mem_model [int unsigned];
  int           checks = 0;
  int           failures = 0;
  int           ack_lat = 10;
  bit           txn_active = 1'b0;
  int           txn_cnt = 0;
  logic [15:0]  exp_miss = 16'd0;

  function automatic logic [31:0] word_of(input int unsigned k, input int unsigned w);
    return 32'hA000_0000 | (k << 8) | w;
  endfunction

  function automatic logic [255:0] blk_init(input int unsigned k);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = word_of(k, w);
    return b;
  endfunction

  function automatic logic [255:0] mem_read(input int unsigned k);
    return mem_model.exists(k) ? mem_model[k] : blk_init(k);
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks each transaction ack_lat cycles after it starts.
  always @(negedge clk_i) begin
    txn_t e;
    mem_ack_i = 1'b0;
    if (!mem_req_o) begin
      txn_active = 1'b0;
    end else begin
      if (!txn_active) begin
        txn_active = 1'b1;
        txn_cnt    = 0;
        check("txn_expected", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("txn_write", 256'(mem_write_o), 256'(e.wr));
          check("txn_addr", 256'(mem_addr_o), 256'(e.addr));
          if (e.wr) check("txn_wdata", mem_data_o, e.data);
        end
      end
      txn_cnt++;
      if (txn_cnt == ack_lat) begin
        mem_ack_i  = 1'b1;
        txn_active = 1'b0;
        if (mem_write_o) mem_model[mem_addr_o >> 5] = mem_data_o;
        else             mem_data_i = mem_read(mem_addr_o >> 5);
      end
    end
  end

  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input int exp_stall,
                            input string tag);
    int stalls = 0;
    @(posedge clk_i); #1;
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    @(negedge clk_i);
    while (cpu_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk_i);
    end
    check({tag, "_stall"}, 256'(stalls), 256'(exp_stall));
    check({tag, "_data"}, 256'(cpu_data_o), 256'(exp_data));
    @(posedge clk_i); #1;
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'b0;
  endtask

  initial begin
    logic [255:0] b;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
    mem_ack_i = 1'b0; mem_data_i = 256'h0;
    b = blk_init(0);
    b[31:0]  = 32'd5;
    b[63:32] = 32'd7;
    mem_model[0] = b;

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_mem_req", 256'(mem_req_o), 256'(0));
    check("rst_mem_write", 256'(mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    check("rst_mem_data", mem_data_o, 256'(0));
    check("rst_stall", 256'(cpu_stall_o), 256'(0));
    check("rst_miss_cnt", 256'(miss_cnt_o), 256'(0));

    // Cold load miss, 10-cycle refill
    exp_q.push_back('{1'b0, 32'h0, 256'h0});
    cpu_access(1'b0, 32'h0, 32'h0, 32'd5, 11, "cold_load");
    exp_miss = 16'd1;
    check("cold_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));

    cpu_access(1'b0, 32'h4, 32'h0, 32'd7, 0, "load_hit");
    cpu_access(1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 0, "store_hit");
    cpu_access(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 0, "load_after_store");
    check("hit_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));

    // Dirty conflict miss on index 0
    ack_lat = 3;
    b = mem_model[0];
    b[95:64] = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, 32'h0, b});
    exp_q.push_back('{1'b0, 32'h200, 256'h0});
    cpu_access(1'b0, 32'h200, 32'h0, word_of(16, 0), 7, "dirty_miss");
    exp_miss = 16'd2;
    check("dirty_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));

    exp_q.push_back('{1'b0, 32'h0, 256'h0});
    cpu_access(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 4, "reload_8");
    exp_miss = 16'd3;
    check("reload_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));

    // Clean store miss: refill then merge, line becomes dirty
    exp_q.push_back('{1'b0, 32'h40, 256'h0});
    cpu_access(1'b1, 32'h44, 32'h1234, 32'h0, 4, "store_miss");
    exp_miss = 16'd4;
    check("store_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));
    cpu_access(1'b0, 32'h44, 32'h0, 32'h1234, 0, "store_miss_hit");

    b = blk_init(2);
    b[63:32] = 32'h1234;
    exp_q.push_back('{1'b1, 32'h40, b});
    exp_q.push_back('{1'b0, 32'h240, 256'h0});
    cpu_access(1'b0, 32'h244, 32'h0, word_of(18, 1), 7, "evict_line2");
    exp_miss = 16'd5;
    check("evict_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));

    // Reset during the fifth ALLOCATE cycle
    ack_lat = 50;
    exp_q.push_back('{1'b0, 32'h400, 256'h0});
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h400;
    repeat (5) @(posedge clk_i);
    #1;
    check("pre_rst_req", 256'(mem_req_o), 256'(1));
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_req", 256'(mem_req_o), 256'(0));
    check("mid_rst_miss_cnt", 256'(miss_cnt_o), 256'(0));
    check("mid_rst_stall", 256'(cpu_stall_o), 256'(0));
    exp_miss = 16'd0;

    ack_lat = 3;
    exp_q.push_back('{1'b0, 32'h0, 256'h0});
    cpu_access(1'b0, 32'h0, 32'h0, 32'd5, 4, "post_rst_load");
    exp_miss = 16'd1;
    check("post_rst_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));

    repeat (3) @(negedge clk_i);
    check("txn_queue_drained", 256'(exp_q.size()), 256'(0));
    check("final_mem_req", 256'(mem_req_o), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
